// File: rtl/fft_input_collector_pkg.sv
`default_nettype none
// ============================================================================
// Module : fft_input_collector_pkg
// Brief  : Shared constants, complex word type and bank-state encoding for
//          the FFT input collector.
// Rev    : 1.0  initial release
// ============================================================================
package fft_input_collector_pkg;

    localparam int FFT_N    = 16;
    localparam int IN_W     = 16;
    localparam int IN_FRAC  = 8;
    localparam int OUT_FRAC = 16;
    localparam int ADDR_W   = $clog2(FFT_N);
    localparam int CPLX_W   = 64;
    localparam int FRAME_W  = FFT_N * CPLX_W;
    localparam int CNT_W    = 8;

    typedef struct packed {
        logic [31:0] re;
        logic [31:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

    // Exact Q(IN_W-IN_FRAC).IN_FRAC -> Q16.16 conversion, imaginary part zero.
    function automatic cplx_t pack_sample(input logic [IN_W-1:0] s);
        cplx_t c;
        c.re = {{(32-IN_W){s[IN_W-1]}}, s} << (OUT_FRAC - IN_FRAC);
        c.im = 32'h0;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_input_collector_if.sv
`default_nettype none
// ============================================================================
// Module : fft_input_collector_if
// Brief  : Sample-in / frame-out handshake bundle for the FFT input collector.
// Rev    : 1.0  initial release
// ============================================================================
interface fft_input_collector_if;
    import fft_input_collector_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [IN_W-1:0]     in_data;
    logic                clear;
    logic                frame_valid;
    logic                frame_ready;
    logic [FRAME_W-1:0]  frame_data;
    logic [CNT_W-1:0]    frame_cnt;

    modport master (
        output in_valid, in_data, clear, frame_ready,
        input  in_ready, frame_valid, frame_data, frame_cnt
    );

    modport slave (
        input  in_valid, in_data, clear, frame_ready,
        output in_ready, frame_valid, frame_data, frame_cnt
    );

endinterface
`default_nettype wire

// File: rtl/fft_input_collector_frame_bank.sv
`default_nettype none
// ============================================================================
// Module : fft_frame_bank
// Brief  : FFT_N x IN_W sample register file; raw samples are stored and
//          converted to packed complex words on the flat read port.
// Rev    : 1.0  initial release
// ============================================================================
module fft_frame_bank
    import fft_input_collector_pkg::*;
(
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                i_we,
    input  wire logic [ADDR_W-1:0]   i_addr,
    input  wire logic [IN_W-1:0]     i_data,
    output logic      [FRAME_W-1:0]  o_frame
);

    logic [IN_W-1:0] r_mem [FFT_N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FFT_N; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_addr] <= i_data;
        end
    end

    generate
        for (genvar k = 0; k < FFT_N; k++) begin : g_word
            assign o_frame[k*CPLX_W +: CPLX_W] = pack_sample(r_mem[k]);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/fft_input_collector.sv
`default_nettype none
// ============================================================================
// Module : fft_input_collector
// Brief  : Serial-to-parallel, double-buffered frame collector feeding the
//          16-point FFT stage chain.
// Rev    : 1.0  initial release
// ============================================================================
module fft_input_collector
    import fft_input_collector_pkg::*;
(
    input  wire logic           clk,
    input  wire logic           rst,
    fft_input_collector_if.slave bus
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(FFT_N - 1);

    logic                r_run;
    bank_state_t         r_state     [2];
    bank_state_t         w_state_nxt [2];
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic                r_wr_bank;
    logic                r_rd_bank;
    logic [CNT_W-1:0]    r_frame_cnt;
    logic [FRAME_W-1:0]  w_bank_frame [2];

    logic                w_in_ready;
    logic                w_frame_valid;
    logic                w_handoff;
    logic                w_wr;
    logic                w_last;

    // r_run holds in_ready low until the first clock edge after reset release.
    assign w_in_ready    = r_run && (r_state[r_wr_bank] != BANK_FULL);
    assign w_frame_valid = (r_state[r_rd_bank] == BANK_FULL);
    assign w_handoff     = w_frame_valid && bus.frame_ready;
    assign w_wr          = bus.in_valid && w_in_ready && !bus.clear;
    assign w_last        = (r_wr_ptr == c_LAST_ADDR);

    generate
        for (genvar b = 0; b < 2; b++) begin : g_bank
            fft_frame_bank u_bank (
                .clk     (clk),
                .rst     (rst),
                .i_we    (w_wr && (r_wr_bank == 1'(b))),
                .i_addr  (r_wr_ptr),
                .i_data  (bus.in_data),
                .o_frame (w_bank_frame[b])
            );
        end
    endgenerate

    // Handoff only touches a FULL bank and writes only touch a non-FULL bank,
    // so the two updates never collide on the same bank.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_state_nxt[b] = r_state[b];
            if (w_handoff && (r_rd_bank == 1'(b))) begin
                w_state_nxt[b] = BANK_EMPTY;
            end
            if (r_wr_bank == 1'(b)) begin
                if (bus.clear) begin
                    if (r_state[b] == BANK_FILLING) begin
                        w_state_nxt[b] = BANK_EMPTY;
                    end
                end else if (w_wr) begin
                    w_state_nxt[b] = w_last ? BANK_FULL : BANK_FILLING;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state[0] <= BANK_EMPTY;
            r_state[1] <= BANK_EMPTY;
        end else begin
            r_state[0] <= w_state_nxt[0];
            r_state[1] <= w_state_nxt[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run       <= 1'b0;
            r_wr_ptr    <= '0;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_run <= 1'b1;
            if (bus.clear) begin
                r_wr_ptr <= '0;
            end else if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_last) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            if (w_handoff) begin
                r_rd_bank   <= ~r_rd_bank;
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.frame_valid = w_frame_valid;
    assign bus.frame_data  = w_bank_frame[r_rd_bank];
    assign bus.frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire
